act_loader: RTL
===============

Name: act_loader

Overview:
Upstream feeder for the activation buffer. Accepts a 32-bit activation word stream with a valid/ready handshake and packs every 4 words (16 int8 activations) into one 128-bit vector. Writes each vector into buffer write port A at consecutive addresses from a programmed base. The controller starts it with a start pulse and sees a done pulse when the load completes.

Parameters:
IN_WIDTH, 32, stream word width (4 activations of 8 bits)
DATA_WIDTH, 128, packed vector width; must equal 4*IN_WIDTH
ADDR_WIDTH, 16, buffer address width
CNT_WIDTH, 17, width of the vector-count fields (holds 0..2^ADDR_WIDTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle command pulse; sampled only in IDLE
base_addr  in  ADDR_WIDTH  first buffer address, captured on start
num_vecs  in  CNT_WIDTH  number of vectors to load, captured on start
in_valid  in  1  stream word valid
in_data  in  IN_WIDTH  stream word; byte 0 is bits [7:0]
in_last  in  1  final word of the stream, qualified by in_valid
in_ready  out  1  loader accepts a word
we_a  out  1  buffer write enable
addr_a  out  ADDR_WIDTH  buffer write address
wdata_a  out  DATA_WIDTH  buffer write data
busy  out  1  high in LOAD
done  out  1  one-cycle completion pulse
vecs_written  out  CNT_WIDTH  vectors written in the current or last load
short_err  out  1  sticky: in_last arrived before num_vecs vectors; cleared on the next accepted start

Behaviour:
- Reset (async, rst=1): state=IDLE. in_ready, we_a, busy, done and short_err are 0. addr_a, wdata_a and vecs_written are 0. The lane index and pack register are cleared.
- A reset in the middle of a load discards any partial vector, and no write is issued afterwards.
- The word handshake occurs when in_valid && in_ready.
- States are IDLE, LOAD and DONE.
- IDLE: in_ready=0. When start=1, capture base_addr and num_vecs, clear vecs_written, lane and short_err.
  - If num_vecs==0, go to DONE and issue no write.
  - Otherwise go to LOAD.
- LOAD: busy=1, and in_ready=1 combinationally from state.
  - Each handshake places in_data into lane L of the pack register, at bits [32L+31:32L], then L increments.
  - A vector closes on a handshake with L==3, or on a handshake with in_last=1.
  - On close, the unfilled lanes are zero.
  - The next cycle shows we_a=1 for exactly one cycle, with addr_a=base+vecs_written (mod 2^ADDR_WIDTH, so it wraps) and wdata_a=the packed vector.
  - vecs_written increments in that same cycle.
  - The outputs are registered, so write latency is 1 cycle after the closing handshake.
  - Back-to-back streaming is supported: 4 words/vector at 1 word/cycle with no bubbles. A new vector fills while the previous write is presented.
- Completion:
  - The closing handshake that makes vecs_written+1==num_vecs moves the block to DONE. in_ready drops the cycle after that handshake, and excess words are never accepted.
  - A close caused by in_last with vecs_written+1<num_vecs also moves the block to DONE and sets short_err.
- DONE: done=1 for one cycle; this is the same cycle as the final we_a, if any. The block then returns to IDLE.
- vecs_written holds its value until the next start.
- in_last on a word that also completes lane 3 gives a normal full vector, with no padding.
- start during LOAD or DONE is ignored.
- The data path is bit-exact with no arithmetic. The address adder is ADDR_WIDTH bits, so it wraps.

Decomposition:
- Shared package: state encoding (IDLE/LOAD/DONE), LANES=DATA_WIDTH/IN_WIDTH=4, and the lane-index width.
- One natural sub-module, act_packer: lane counter plus pack register, with close and zero-pad logic. The FSM and address generation stay in act_loader.

Test Plan:
1. Basic: base=0x0010, num_vecs=2, 8 words 0x03020100..0x1F1E1D1C, continuous valid.
   -> we_a pulses 1 cycle after words 4 and 8, at addr 0x0010 then 0x0011.
   -> First wdata=0x0F0E0D0C_0B0A0908_07060504_03020100.
   -> done coincides with the second write, and vecs_written=2.
2. Short stream: num_vecs=3, 6 words with in_last on word 6.
   -> 2 writes; the second has the upper 64 bits zero.
   -> done=1, short_err=1, vecs_written=2.
3. Wrap and excess words: base=0xFFFF, num_vecs=2, 12 words offered.
   -> Writes at 0xFFFF then 0x0000.
   -> in_ready=0 after the 8th handshake, and words 9-12 are not accepted.
4. Backpressure gaps and zero count: in_valid toggling randomly.
   -> Identical write data and addresses to scenario 1.
   -> With num_vecs=0: done pulses the cycle after start, and there is no we_a.
5. Reset mid-load: assert rst after 2 words of vector 1.
   -> Outputs are 0 immediately (async).
   -> No we_a appears after release.
   -> A new start loads correctly from lane 0.
6. start pulsed during LOAD -> ignored; base and count are unchanged, verified by the write addresses.

Source files
------------

// File: rtl/act_loader_pkg.sv
// Shared definitions for the activation loader: FSM encoding and lane geometry.
package act_loader_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/act_packer.sv
// Lane counter and pack register: gathers stream words into one wide vector,
// zero-padding the unfilled upper lanes when a vector closes early.
module act_packer
    import act_loader_pkg::*;
#(
    parameter int IN_WIDTH   = 32,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_last,
    output logic                  close,
    output logic [DATA_WIDTH-1:0] vec
);

    logic [LANE_W-1:0]     lane;
    logic [DATA_WIDTH-1:0] pack;

    assign close = accept && ((lane == LANE_W'(LANES - 1)) || in_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane <= '0;
            pack <= '0;
        end else if (clear) begin
            lane <= '0;
        end else if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane == LANE_W'(i)) begin
                    pack[i*IN_WIDTH +: IN_WIDTH] <= in_data;
                end
            end
            lane <= close ? '0 : lane + LANE_W'(1);
        end
    end

    // Closing vector: earlier lanes from the register, the current word in
    // its lane, and zeros above it so stale data never leaks into a write.
    always_comb begin
        vec = '0;
        for (int i = 0; i < LANES; i++) begin
            if (LANE_W'(i) < lane) begin
                vec[i*IN_WIDTH +: IN_WIDTH] = pack[i*IN_WIDTH +: IN_WIDTH];
            end else if (LANE_W'(i) == lane) begin
                vec[i*IN_WIDTH +: IN_WIDTH] = in_data;
            end
        end
    end

endmodule

// File: rtl/act_loader.sv
// Activation buffer feeder: packs 32-bit stream words into 128-bit vectors
// and writes them to buffer port A at consecutive addresses from a base.
module act_loader
    import act_loader_pkg::*;
#(
    parameter int IN_WIDTH   = 32,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_vecs,
    input  logic                  in_valid,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  we_a,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [DATA_WIDTH-1:0] wdata_a,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  vecs_written,
    output logic                  short_err
);

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_WIDTH-1:0]  num_q;
    logic [CNT_WIDTH-1:0]  vw_next;
    logic [DATA_WIDTH-1:0] packed_vec;
    logic                  accept;
    logic                  close;
    logic                  start_go;

    assign in_ready = (state == LOAD);
    assign busy     = (state == LOAD);
    assign accept   = in_valid && in_ready;
    assign start_go = (state == IDLE) && start;
    assign vw_next  = vecs_written + CNT_WIDTH'(1);

    act_packer #(
        .IN_WIDTH   (IN_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_go),
        .accept  (accept),
        .in_data (in_data),
        .in_last (in_last),
        .close   (close),
        .vec     (packed_vec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DONE lasts one cycle and lines up with the final registered write.
    always_comb begin
        next_state = state;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (num_vecs == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (close && ((vw_next == num_q) || in_last)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q       <= '0;
            num_q        <= '0;
            vecs_written <= '0;
            we_a         <= 1'b0;
            addr_a       <= '0;
            wdata_a      <= '0;
            short_err    <= 1'b0;
        end else begin
            we_a <= 1'b0;
            if (start_go) begin
                base_q       <= base_addr;
                num_q        <= num_vecs;
                vecs_written <= '0;
                short_err    <= 1'b0;
            end
            if (close) begin
                we_a         <= 1'b1;
                addr_a       <= base_q + vecs_written[ADDR_WIDTH-1:0];
                wdata_a      <= packed_vec;
                vecs_written <= vw_next;
                if (in_last && (vw_next < num_q)) begin
                    short_err <= 1'b1;
                end
            end
        end
    end

endmodule
